// File: rtl/program_sequencer_pkg.sv
// rtl/program_sequencer_pkg.sv - shared opcode constants and sequencer state encoding
package program_sequencer_pkg;

  localparam int PM_ID_INS_WIDTH = 13;
  localparam int OPCODE_WIDTH    = 5;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_JMP = 5'b11110;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_HLT = 5'b11111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_OPER  = 3'd3,
    ST_EXEC  = 3'd4,
    ST_HALT  = 3'd5
  } seq_state_t;

  // JMP and HLT are handled here; the decoder sees them as no-ops
  function automatic logic is_ctrl_op(input logic [OPCODE_WIDTH-1:0] opcode);
    return (opcode == OPCODE_JMP) || (opcode == OPCODE_HLT);
  endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// rtl/program_sequencer_if.sv - sequencer control, program memory and decoder enable bundle
interface program_sequencer_if #(
  parameter int PM_ADDR_WIDTH = 8,
  parameter int INS_WIDTH     = program_sequencer_pkg::PM_ID_INS_WIDTH
);

  logic                     Start;
  logic                     Stop;
  logic [PM_ADDR_WIDTH-1:0] PM_Addr;
  logic                     PM_RE;
  logic [INS_WIDTH-1:0]     PM_Data;
  logic [INS_WIDTH-1:0]     Ins;
  logic                     Dec_DataMem_WE;
  logic                     Dec_Reg_CE;
  logic                     Dec_Accu_CE;
  logic                     Dec_Carry_CE;
  logic                     DataMem_WE;
  logic                     Reg_CE;
  logic                     Accu_CE;
  logic                     Carry_CE;
  logic                     Busy;
  logic                     Halted;
  logic                     Retire;

  modport master (
    input  Start, Stop, PM_Data,
    input  Dec_DataMem_WE, Dec_Reg_CE, Dec_Accu_CE, Dec_Carry_CE,
    output PM_Addr, PM_RE, Ins,
    output DataMem_WE, Reg_CE, Accu_CE, Carry_CE,
    output Busy, Halted, Retire
  );

  modport slave (
    output Start, Stop, PM_Data,
    output Dec_DataMem_WE, Dec_Reg_CE, Dec_Accu_CE, Dec_Carry_CE,
    input  PM_Addr, PM_RE, Ins,
    input  DataMem_WE, Reg_CE, Accu_CE, Carry_CE,
    input  Busy, Halted, Retire
  );

endinterface

// File: rtl/program_sequencer_program_counter.sv
// rtl/program_sequencer_program_counter.sv - program counter with clear, jump load and wrapping increment
module program_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - fetch/load/oper/exec control FSM with stop latch and gated datapath enables
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int PM_ADDR_WIDTH = 8,
  parameter int INS_WIDTH     = PM_ID_INS_WIDTH
) (
  input  logic                Clk,
  input  logic                nRst,
  program_sequencer_if.master bus
);

  seq_state_t state_q, state_d;

  logic                     stop_pend_q;
  logic                     stop_seen;
  logic [INS_WIDTH-1:0]     ins_q;
  logic [OPCODE_WIDTH-1:0]  opcode;
  logic                     exec_q, pm_re_q, busy_q, halted_q;
  logic                     pc_inc, pc_load;
  logic [PM_ADDR_WIDTH-1:0] pc, jmp_target;
  logic                     gate;

  assign opcode     = ins_q[INS_WIDTH-1 -: OPCODE_WIDTH];
  assign jmp_target = PM_ADDR_WIDTH'(ins_q[7:0]);
  assign stop_seen  = stop_pend_q | bus.Stop;

  program_counter #(.WIDTH(PM_ADDR_WIDTH)) u_pc (
    .clk      (Clk),
    .rst_n    (nRst),
    .clr      (1'b0),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (jmp_target),
    .pc       (pc)
  );

  always_comb begin
    state_d = state_q;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (bus.Start && !bus.Stop) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_OPER;
      ST_OPER:  state_d = ST_EXEC;
      ST_EXEC: begin
        pc_load = (opcode == OPCODE_JMP);
        pc_inc  = (opcode != OPCODE_JMP);
        if (opcode == OPCODE_HLT) state_d = ST_HALT;
        else if (stop_seen)       state_d = ST_IDLE;
        else                      state_d = ST_FETCH;
      end
      ST_HALT: begin
        if (bus.Stop)       state_d = ST_IDLE;
        else if (bus.Start) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= ST_IDLE;
      stop_pend_q <= 1'b0;
      ins_q       <= '0;
      exec_q      <= 1'b0;
      pm_re_q     <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      exec_q   <= (state_d == ST_EXEC);
      pm_re_q  <= (state_d == ST_FETCH);
      busy_q   <= (state_d inside {ST_FETCH, ST_LOAD, ST_OPER, ST_EXEC});
      halted_q <= (state_d == ST_HALT);
      if (state_q == ST_LOAD) ins_q <= bus.PM_Data;
      if (state_d == ST_IDLE)
        stop_pend_q <= 1'b0;
      else if (bus.Stop && (state_q inside {ST_FETCH, ST_LOAD, ST_OPER, ST_EXEC}))
        stop_pend_q <= 1'b1;
    end
  end

  assign gate = exec_q & ~is_ctrl_op(opcode);

  assign bus.PM_Addr    = pc;
  assign bus.PM_RE      = pm_re_q;
  assign bus.Ins        = ins_q;
  assign bus.Busy       = busy_q;
  assign bus.Halted     = halted_q;
  assign bus.Retire     = exec_q;
  assign bus.DataMem_WE = bus.Dec_DataMem_WE & gate;
  assign bus.Reg_CE     = bus.Dec_Reg_CE     & gate;
  assign bus.Accu_CE    = bus.Dec_Accu_CE    & gate;
  assign bus.Carry_CE   = bus.Dec_Carry_CE   & gate;

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - randomized program/control stimulus against an instruction-level reference model
module tb_program_sequencer;

  localparam int AW = 8;
  localparam int IW = 13;
  localparam logic [4:0] M_JMP = 5'b11110;
  localparam logic [4:0] M_HLT = 5'b11111;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  logic Clk  = 1'b0;
  logic nRst = 1'b0;
  always #5 Clk = ~Clk;

  program_sequencer_if #(.PM_ADDR_WIDTH(AW), .INS_WIDTH(IW)) bus ();

  program_sequencer #(.PM_ADDR_WIDTH(AW), .INS_WIDTH(IW)) dut (
    .Clk  (Clk),
    .nRst (nRst),
    .bus  (bus)
  );

  logic [IW-1:0] mem [256];

  always @(posedge Clk) if (bus.PM_RE) bus.PM_Data <= mem[bus.PM_Addr];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode plus position within the 4-cycle instruction slot
  int          m_mode;
  int          m_phase;
  logic [7:0]  m_pc;
  logic [12:0] m_ins;
  bit          m_stop;
  bit          start, stop;
  logic [3:0]  dec;

  task automatic model_reset();
    m_mode = M_IDLE; m_phase = 0; m_pc = 8'h00; m_ins = '0; m_stop = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit sp);
    case (m_mode)
      M_IDLE: if (st && !sp) begin m_mode = M_RUN; m_phase = 0; end
      M_RUN: begin
        if (sp) m_stop = 1'b1;
        if (m_phase == 1) m_ins = mem[m_pc];
        if (m_phase < 3) begin
          m_phase++;
        end else begin
          if (m_ins[12:8] == M_JMP) m_pc = m_ins[7:0];
          else                      m_pc = m_pc + 8'd1;
          if (m_ins[12:8] == M_HLT) m_mode = M_HALT;
          else if (m_stop) begin m_mode = M_IDLE; m_stop = 1'b0; end
          else m_phase = 0;
        end
      end
      default: begin
        if (sp) begin m_mode = M_IDLE; m_stop = 1'b0; end
        else if (st) begin m_mode = M_RUN; m_phase = 0; end
      end
    endcase
  endtask

  task automatic check_all();
    bit run, exe, ctrl;
    run  = (m_mode == M_RUN);
    exe  = run && (m_phase == 3);
    ctrl = (m_ins[12:8] == M_JMP) || (m_ins[12:8] == M_HLT);
    check("pm_re",   bus.PM_RE,   run && m_phase == 0);
    check("pm_addr", bus.PM_Addr, m_pc);
    check("ins",     bus.Ins,     m_ins);
    check("busy",    bus.Busy,    run);
    check("halted",  bus.Halted,  m_mode == M_HALT);
    check("retire",  bus.Retire,  exe);
    check("gated_en", {bus.DataMem_WE, bus.Reg_CE, bus.Accu_CE, bus.Carry_CE},
          (exe && !ctrl) ? dec : 4'h0);
  endtask

  task automatic drive();
    bus.Start          = start;
    bus.Stop           = stop;
    bus.Dec_DataMem_WE = dec[3];
    bus.Dec_Reg_CE     = dec[2];
    bus.Dec_Accu_CE    = dec[1];
    bus.Dec_Carry_CE   = dec[0];
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 15))
        0:       mem[i] = {M_JMP, 8'($urandom)};
        1:       mem[i] = {M_HLT, 8'($urandom)};
        default: mem[i] = {5'($urandom_range(0, 29)), 8'($urandom)};
      endcase
    end
    mem[8'h00] = {5'd1, 8'h11};
    mem[8'h40] = {M_JMP, 8'hFE};
    mem[8'hFE] = {5'd2, 8'h33};
    mem[8'hFF] = {5'd3, 8'h44};

    start = 1'b0; stop = 1'b0; dec = 4'h0;
    drive();
    model_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    #1 check_all();
    nRst = 1'b1;

    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge Clk);
      if (m_mode == M_RUN && m_phase == 3 && $urandom_range(0, 40) == 0) begin
        start = 1'b0; stop = 1'b0; dec = 4'hF;
        drive();
        nRst = 1'b0;
        #1;
        check("rst_gated_en", {bus.DataMem_WE, bus.Reg_CE, bus.Accu_CE, bus.Carry_CE}, 4'h0);
        check("rst_retire",   bus.Retire,  1'b0);
        check("rst_busy",     bus.Busy,    1'b0);
        check("rst_pm_addr",  bus.PM_Addr, 8'h00);
        @(posedge Clk);
        @(negedge Clk);
        nRst = 1'b1;
        model_reset();
      end
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 24) == 0);
      dec   = 4'($urandom);
      drive();
      #1 check_all();
      model_step(start, stop);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
